input_flow_control: RTL

Receiver end of the router-to-router link flow control. Accepts flits from the upstream transmitter on `val`, stores them in a local FIFO, and returns `ret` upstream to tell the transmitter the buffer is full. The router core drains the buffer through a show-ahead `empty`/`read`/`dout` port. One instance sits on each router input port.

---
 rtl/noc_pkg.sv | 14 +
 rtl/ifc_fifo_mem.sv | 26 ++
 rtl/input_flow_control.sv | 88 ++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared router link definitions: default flit width, buffer depth, flit type and pointer sizing.
package noc_pkg;

   localparam int FLIT_W    = 32;
   localparam int BUF_DEPTH = 4;

   typedef logic [FLIT_W-1:0] flit_t;

   // Pointer width for a buffer of the given depth; never narrower than one bit
   function automatic int PTR_W(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/ifc_fifo_mem.sv
// Flit storage array for the input buffer: one synchronous write port, one asynchronous read port.
module ifc_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately not reset; stale flits are masked by the owner's count
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/input_flow_control.sv
// Receiver-side link buffer: stores upstream flits, asserts ret when full, show-ahead drain port.
// Define IFC_OVF_CHECK_EN to flag writes attempted while full on a sticky err output.
module input_flow_control
   import noc_pkg::*;
#(
   parameter int DATA_W = FLIT_W,
   parameter int DEPTH  = BUF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              val,
   input  logic [DATA_W-1:0] din,
   output logic              ret,
   output logic              empty,
   input  logic              read,
   output logic [DATA_W-1:0] dout,
   output logic              err
);

   localparam int AW    = PTR_W(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             wr_en;
   logic             rd_en;

   // Flags come only from the count register so ret never depends combinationally on val
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign ret   = full;

   assign wr_en = val && !full;
   assign rd_en = read && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !rd_en) begin
            count <= count + CNT_W'(1);
         end else if (rd_en && !wr_en) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef IFC_OVF_CHECK_EN
   logic err_q;

   // Sticky until reset: upstream sent while ret was high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (val && full) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   ifc_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (dout)
   );

endmodule
